video_sync_gen: RTL

//  15 kHz raster timing generator for the core video path. It produces the pixel

---
 rtl/video_sync_gen_if.sv | 20 ++
 rtl/video_sync_gen.sv | 101 ++++++++++
 2 files changed

// File: rtl/video_sync_gen_if.sv
// Raster timing bus: pixel/line counters plus registered sync, blank, interrupt and flash strobes.
interface video_sync_gen_if;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       hsync_n;
   logic       vsync_n;
   logic       csync_n;
   logic       blank_n;
   logic       int_n;
   logic       frame_tick;
   logic       flash;

   modport master (
      output hcnt, vcnt, hsync_n, vsync_n, csync_n, blank_n, int_n, frame_tick, flash
   );

   modport slave (
      input  hcnt, vcnt, hsync_n, vsync_n, csync_n, blank_n, int_n, frame_tick, flash
   );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator; every output is a register decoded from the next counter state (zero lag vs hcnt/vcnt).
// No backpressure: ce gates all advances, reset overrides ce, frame_tick self-clears.
module video_sync_gen #(
   parameter int H_TOTAL      = 448,
   parameter int H_ACTIVE     = 320,
   parameter int H_SYNC_START = 344,
   parameter int H_SYNC_LEN   = 32,
   parameter int V_TOTAL      = 312,
   parameter int V_ACTIVE     = 256,
   parameter int V_SYNC_START = 280,
   parameter int V_SYNC_LEN   = 4,
   parameter int INT_LEN      = 32,
   parameter int FLASH_DIV    = 16
) (
   input  logic             clkvideo,
   input  logic             reset,
   input  logic             ce,
   video_sync_gen_if.master vid
);
   localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   // 12-bit compares keep sync windows that run past the total from aliasing.
   localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
   localparam logic [11:0] HS_BEG  = 12'(H_SYNC_START);
   localparam logic [11:0] HS_END  = 12'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [11:0] VS_BEG  = 12'(V_SYNC_START);
   localparam logic [11:0] VS_END  = 12'(V_SYNC_START + V_SYNC_LEN);
   localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
   localparam logic [11:0] INT_END = 12'(INT_LEN);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);

   logic [9:0]       hcnt_q, vcnt_q, h_nxt, v_nxt;
   logic [11:0]      h_ext, v_ext;
   logic             h_wrap, v_wrap;
   logic             hs_nxt, vs_nxt, bl_nxt, int_nxt;
   logic             hsync_q, vsync_q, csync_q, blank_q, int_q, tick_q, flash_q;
   logic [DIV_W-1:0] div_q;

   always_comb begin
      h_wrap  = ({2'b00, hcnt_q} == H_LAST);
      v_wrap  = ({2'b00, vcnt_q} == V_LAST);
      h_nxt   = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      v_nxt   = vcnt_q;
      if (h_wrap)
         v_nxt = v_wrap ? 10'd0 : vcnt_q + 10'd1;
      h_ext   = {2'b00, h_nxt};
      v_ext   = {2'b00, v_nxt};
      hs_nxt  = (h_ext >= HS_BEG) && (h_ext < HS_END);
      vs_nxt  = (v_ext >= VS_BEG) && (v_ext < VS_END);
      bl_nxt  = (h_ext < H_ACT) && (v_ext < V_ACT);
      int_nxt = (v_ext == VS_BEG) && (h_ext < INT_END);
   end

   always_ff @(posedge clkvideo) begin
      if (reset) begin
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         csync_q <= 1'b1;
         blank_q <= 1'b1;
         int_q   <= 1'b1;
         tick_q  <= 1'b0;
         flash_q <= 1'b0;
         div_q   <= '0;
      end else begin
         tick_q <= 1'b0;
         if (ce) begin
            hcnt_q  <= h_nxt;
            vcnt_q  <= v_nxt;
            hsync_q <= !hs_nxt;
            vsync_q <= !vs_nxt;
            // Composite sync inverts hsync while vsync is active.
            csync_q <= vs_nxt ? hs_nxt : !hs_nxt;
            blank_q <= bl_nxt;
            int_q   <= !int_nxt;
            if (h_wrap && v_wrap) begin
               tick_q <= 1'b1;
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  flash_q <= !flash_q;
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end
         end
      end
   end

   assign vid.hcnt       = hcnt_q;
   assign vid.vcnt       = vcnt_q;
   assign vid.hsync_n    = hsync_q;
   assign vid.vsync_n    = vsync_q;
   assign vid.csync_n    = csync_q;
   assign vid.blank_n    = blank_q;
   assign vid.int_n      = int_q;
   assign vid.frame_tick = tick_q;
   assign vid.flash      = flash_q;
endmodule
